// File: rtl/mcu32x_pkg.sv
// Shared core-wide definitions for the mcu32x fetch path: data widths, fetch
// stride, reset vector and the instruction-queue entry layout.
package mcu32x_pkg;

  localparam int XLEN       = 32;
  localparam int INST_W     = 32;
  localparam int FETCH_STEP = 4;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  // One buffered instruction; pc in the upper half so a raw dump reads pc first.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// sync_fifo: single-clock in-order FIFO with flush and occupancy count.
// Push and pop in the same cycle are accepted even when full.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    empty     = (count == '0);
    full      = (count == CNT_W'(DEPTH));
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    head_data = storage[rd_ptr];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which slots
  // hold valid data, and leaving the array reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetcher with credit-limited requests,
// in-order buffering and redirect flush. Define IFQ_PERF_CNT_EN for stall_cycles.
module ifetch_queue
  import mcu32x_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_VECTOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] occupancy;
  logic             grant;
  logic             resp_ok;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Credits cover both buffered words and words still in flight, so a return
  // always has a free slot waiting for it.
  always_comb begin
    mem_req = ({1'b0, occupancy} + {1'b0, outstanding} < SUM_W'(DEPTH)) &&
              (outstanding < CNT_W'(MAX_OUTSTANDING)) &&
              !redirect_valid && !reset;
    mem_addr         = fetch_pc;
    grant            = mem_req && mem_gnt;
    resp_ok          = mem_rvalid && (outstanding != '0);
    push             = resp_ok && (drop == '0) && !redirect_valid;
    pop              = inst_valid && inst_ready;
    outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(resp_ok);
    push_entry       = '{pc: resp_pc, data: mem_rdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        // Everything still in flight now belongs to the abandoned path.
        fetch_pc <= word_align(redirect_pc);
        resp_pc  <= word_align(redirect_pc);
        drop     <= outstanding_next;
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(FETCH_STEP);
        if (push) begin
          resp_pc <= resp_pc + XLEN'(FETCH_STEP);
        end else if (resp_ok && drop != '0) begin
          drop <= drop - CNT_W'(1);
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head fields read as zero whenever the queue is empty.
  always_comb begin
    inst_valid = !fifo_empty;
    inst_data  = inst_valid ? head_entry.data : '0;
    inst_pc    = inst_valid ? head_entry.pc   : '0;
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!inst_valid && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    !(mem_rvalid && outstanding == '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized
// traffic against a queue-based reference model and an in-order memory model.
module tb_ifetch_queue;
  import mcu32x_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  ifetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef IFQ_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  bit lat_random = 1'b0;

  typedef struct { logic [31:0] addr; int due; } mem_pend_t;
  typedef struct { logic [31:0] addr; bit stale; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;

  mem_pend_t   mem_pend[$];
  flight_t     m_flight[$];
  inst_t       m_fifo[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_stall    = '0;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_data;
  int          n_grants;
  logic [31:0] last_grant_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance
  // the model to the state the DUT will hold after the coming posedge.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit gnt, input bit ready);
    bit      exp_req;
    bit      exp_valid;
    flight_t f;
    @(negedge clk);
    cyc++;
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_gnt        = gnt;
    inst_ready     = ready;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
    if (rst) begin
      mem_pend.delete();
    end else if (mem_pend.size() != 0 && mem_pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(mem_pend[0].addr);
      void'(mem_pend.pop_front());
    end
    #1;
    exp_req   = !rst && !redir && (m_fifo.size() + m_flight.size() < DEPTH) &&
                (m_flight.size() < MAX_OUT);
    exp_valid = (m_fifo.size() != 0);
    obs_req   = mem_req;
    obs_addr  = mem_addr;
    obs_valid = inst_valid;
    obs_pc    = inst_pc;
    obs_data  = inst_data;

    check("mem_req", mem_req, exp_req);
    if (!rst) begin
      check("mem_addr", mem_addr, m_fetch_pc);
      check("inst_valid", inst_valid, exp_valid);
      if (exp_valid) begin
        check("inst_pc", inst_pc, m_fifo[0].pc);
        check("inst_data", inst_data, m_fifo[0].data);
      end
`ifdef IFQ_PERF_CNT_EN
      check("stall_cycles", stall_cycles, m_stall);
`endif
    end

    if (!rst && mem_req && mem_gnt) begin
      mem_pend.push_back('{addr: mem_addr,
                           due: cyc + (lat_random ? int'($urandom_range(1, 4)) : mem_lat)});
      n_grants++;
      last_grant_addr = mem_addr;
    end

    if (rst) begin
      m_fetch_pc = RESET_PC;
      m_flight.delete();
      m_fifo.delete();
      m_stall = '0;
    end else begin
      if (!exp_valid && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (exp_valid && ready && !redir) void'(m_fifo.pop_front());
      if (mem_rvalid && m_flight.size() != 0) begin
        f = m_flight.pop_front();
        if (!f.stale && !redir) m_fifo.push_back('{pc: f.addr, data: mem_word(f.addr)});
      end
      if (redir) begin
        m_fifo.delete();
        foreach (m_flight[i]) m_flight[i].stale = 1'b1;
        m_fetch_pc = {rpc[31:2], 2'b00};
      end else if (exp_req && gnt) begin
        m_flight.push_back('{addr: m_fetch_pc, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      check("no_overflow", 32'(m_fifo.size() <= DEPTH), 32'd1);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_valid(input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      if (obs_valid) break;
    end
    if (k == bound) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; inst_ready = 1'b0;

    // Streaming: 1-cycle memory, decode always ready.
    mem_lat = 1;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      if (k == 1) begin
        check("rst_inst_data", obs_data, 32'h0);
        check("rst_inst_pc", obs_pc, 32'h0);
        check("rst_mem_addr", obs_addr, RESET_PC);
        check("first_req", obs_req, 1'b1);
      end
      if (k <= 2) check("stream_empty", obs_valid, 1'b0);
      else begin
        check("stream_valid", obs_valid, 1'b1);
        check("stream_pc", obs_pc, 32'(4 * (k - 3)));
      end
    end

    // Back-pressure: queue fills to DEPTH, requests stop at 0xC.
    do_reset();
    n_grants = 0;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("bp_grants", 32'(n_grants), 32'd4);
    check("bp_last_addr", last_grant_addr, 32'h0000_000C);
    check("bp_req_low", obs_req, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("bp_drain_pc", obs_pc, 32'(4 * k));
    end

    // 3-cycle memory, redirect with two requests in flight.
    do_reset();
    mem_lat = 3;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("lat3_second_addr", obs_addr, 32'h4);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("lat3_redir_addr", obs_addr, 32'h0000_0100);
    check("lat3_redir_valid", obs_valid, 1'b0);
    wait_valid(30);
    check("lat3_first_pc", obs_pc, 32'h0000_0100);
    check("lat3_first_data", obs_data, mem_word(32'h0000_0100));

    // Unaligned redirect coinciding with a returning word.
    mem_lat = 1;
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("redir_req", obs_req, 1'b1);
    check("redir_align_addr", obs_addr, 32'h0000_0200);
    check("redir_valid_low", obs_valid, 1'b0);
    wait_valid(20);
    check("redir_first_pc", obs_pc, 32'h0000_0200);

    // Grant withheld: address held; PC wraps past the top of memory.
    do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("hold_req", obs_req, 1'b1);
      check("hold_addr", obs_addr, 32'hFFFF_FFFC);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("wrap_addr", obs_addr, 32'h0000_0000);
    wait_valid(20);
    check("wrap_pc_top", obs_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("wrap_pc_zero", obs_pc, 32'h0000_0000);

`ifdef IFQ_PERF_CNT_EN
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      if (k == 1) check("perf_reset", stall_cycles, 32'd0);
      if (k == 8) check("perf_seven", stall_cycles, 32'd7);
    end
`endif

    // Randomized traffic with variable latency, redirects and rare resets.
    lat_random = 1'b1;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 99) < 4,
           $urandom(),
           $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 70);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue sitting between the unified `memory` block and the `control_unit` decode path. It generates sequential 32-bit instruction fetch requests from an internal fetch PC and buffers returned words in an in-order FIFO. It presents instructions, tagged with their PC, to decode over a valid/ready handshake, and flushes on branch/jump redirect. It replaces the free-running single-word `fetch` stage as the producer of `instruction`.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum granted-but-unreturned memory requests, 1..DEPTH.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  32  fetch word address.
- `mem_gnt`  in  1  memory accepts request this cycle.
- `mem_rvalid`  in  1  read data returned, in request order.
- `mem_rdata`  in  32  returned instruction word.
- `inst_valid`  out  1  head entry valid.
- `inst_data`  out  32  head instruction.
- `inst_pc`  out  32  PC of head instruction.
- `inst_ready`  in  1  decode consumes head.
- `stall_cycles`  out  32  present only with `IFQ_PERF_CNT_EN`.

## Operation
- Registers: `fetch_pc`, FIFO (data+PC per entry), `outstanding` count, `drop` count.
- Issue condition: `occupancy + outstanding < DEPTH` and `outstanding < MAX_OUTSTANDING` and not `redirect_valid`.
- Request handshake: once `mem_req` is high, `mem_addr` is held stable until `mem_gnt`, except on redirect. On grant, `fetch_pc += 4` (mod 2^32 wrap, 0xFFFF_FFFC→0x0), `outstanding++`.
- Response: `mem_rvalid` decrements `outstanding`. If `drop > 0`, the word is discarded and `drop--`. Otherwise it is pushed with its PC; a separate `resp_pc` register tracks return addresses.
- Pop: `inst_valid && inst_ready` removes the head. Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect (priority over everything): FIFO emptied; `fetch_pc <= {redirect_pc[31:2],2'b00}`; `drop <= outstanding` (plus 1 if a grant occurs the same cycle, minus 1 if a response returns the same cycle). A head handshake in the redirect cycle counts as consumed.
- `mem_rvalid` with `outstanding == 0` is a protocol error: ignored, flagged by assertion.
- Overflow is impossible by the credit rule; the bench asserts it.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=RESET_PC, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `stall_cycles`=0; all counters 0.
- First `mem_req` occurs in the first cycle after `reset` deasserts.
- Redirect in cycle N → `mem_req` with new address in N+1; `inst_valid` low in N+1.
- `mem_rvalid` in cycle M → `inst_valid` in M+1. The FIFO is registered, with no bypass.
- With 1-cycle memory and `inst_ready` held high: one instruction per cycle sustained.
- `reset` mid-transfer: all state cleared next edge; late responses after reset are protocol errors (memory is reset by the same `reset`).

## Configuration
- `IFQ_PERF_CNT_EN` defined: `stall_cycles` port exists. It increments when `inst_valid==0` and not reset, saturates at 32'hFFFF_FFFF, and clears on reset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `mcu32x_pkg`: `XLEN`=32, `INST_W`=32, `FETCH_STEP`=4, `RESET_VECTOR` default.
- One sub-module: `sync_fifo` (parameterised width/depth, push/pop/flush, `count` output), holding {pc, data}.
- The credit/drop logic and fetch PC live in `ifetch_queue`.

## Test plan
- Reset, RESET_PC=0, memory 1-cycle, `inst_ready`=1 → `inst_pc` 0x0,0x4,0x8,0xC on consecutive cycles starting cycle 3.
- `inst_ready`=0 for 10 cycles → exactly DEPTH=4 entries fill, `mem_req` drops, no requests beyond address 0xC.
- 3-cycle memory latency, redirect to 0x100 with 2 outstanding → the two stale words are dropped; the first `inst_pc` after that is 0x100.
- Redirect to 0x203 → fetch at 0x200; redirect coinciding with `mem_gnt` and `mem_rvalid` → drop count correct, no stale output.
- `mem_gnt` held low 5 cycles → `mem_addr` stable throughout; `fetch_pc` wrap from 0xFFFF_FFFC → next 0x0.
- With `IFQ_PERF_CNT_EN`: 7 empty cycles after reset → `stall_cycles`=7; without the macro, the build has no `stall_cycles` port.
